// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   port and the data port of the pipelined core. Each access is sequenced
//   through a fixed-latency grant FSM and returns a one-cycle ack. The data
//   port has priority. A starvation counter forces a fetch grant after
//   STARVE_MAX consecutive data grants that were issued while fetch was waiting.
//
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   if_req/if_addr         fetch request (held until if_ack) and address
//   if_rdata/if_ack        fetched word, valid with the one-cycle ack
//   d_req/d_we/d_addr      data request (held until d_ack), 1 = store
//   d_wdata                store data
//   d_rdata/d_ack          load data, valid with the one-cycle ack
//   mem_en/mem_we          memory access / write enable
//   mem_addr/mem_wdata     memory address / write data, stable for a grant
//   mem_rdata              memory read data, sampled in the completion cycle
//   stall_if/stall_mem     requester is waiting (req & ~ack)
//   busy                   FSM not idle
//   perf_if_wait           stall_if cycle counter (0 unless ARB_PERF_CNT_EN)
//   perf_d_wait            stall_mem cycle counter (0 unless ARB_PERF_CNT_EN)
//
// Build option: define ARB_PERF_CNT_EN to generate the 16-bit saturating
// wait counters. When it is undefined, both counter outputs are tied to 0.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access in flight, mem_en low
// GNT_I | fetch access in flight, lat_cnt counts down to completion
// GNT_D | data access in flight, lat_cnt counts down to completion

module mem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,   // 1..15
  parameter int STARVE_MAX = 4    // 1..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy,
  output logic [15:0]       perf_if_wait,
  output logic [15:0]       perf_d_wait
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          lat_cnt_q;
  logic [3:0]          starve_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic done;
  logic arb_ok;
  logic fetch_forced;
  logic grant_d;
  logic grant_i;

  // A request that is still high in its own ack cycle is taken as the next
  // request from that port. This lets a continuously asserted d_req stream
  // back-to-back accesses, which is what the starvation counter guards
  // against.
  always_comb begin
    done         = 1'b0;
    arb_ok       = 1'b0;
    fetch_forced = 1'b0;
    grant_d      = 1'b0;
    grant_i      = 1'b0;
    state_d      = state_q;

    done         = (state_q != IDLE) && (lat_cnt_q == 4'd0);
    arb_ok       = (state_q == IDLE) || done;
    fetch_forced = if_req && (starve_q == STARVE_LIM);
    grant_d      = arb_ok && d_req && !fetch_forced;
    grant_i      = arb_ok && if_req && !grant_d;

    if (grant_d) begin
      state_d = GNT_D;
    end else if (grant_i) begin
      state_d = GNT_I;
    end else if (done) begin
      state_d = IDLE;
    end
  end

  // Acks are combinational in the completion cycle so that the requester sees
  // them, and the read data, MEM_LAT cycles after acceptance. They are masked
  // by reset so an access abandoned in its completion cycle never acks.
  assign if_ack    = !reset && (state_q == GNT_I) && (lat_cnt_q == 4'd0);
  assign d_ack     = !reset && (state_q == GNT_D) && (lat_cnt_q == 4'd0);
  assign if_rdata  = if_ack ? mem_rdata : if_rdata_q;
  assign d_rdata   = (d_ack && !mem_we) ? mem_rdata : d_rdata_q;
  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_cnt_q  <= 4'd0;
      starve_q   <= 4'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q <= state_d;

      if (grant_d || grant_i) begin
        mem_en    <= 1'b1;
        mem_we    <= grant_d && d_we;
        mem_addr  <= grant_d ? d_addr : if_addr;
        // A fetch never writes, so the write data bus keeps its last value.
        if (grant_d) begin
          mem_wdata <= d_wdata;
        end
        lat_cnt_q <= LAT_INIT;
      end else if (done) begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
      end else if (lat_cnt_q != 4'd0) begin
        lat_cnt_q <= lat_cnt_q - 4'd1;
      end

      if (if_ack) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_ack && !mem_we) begin
        d_rdata_q <= mem_rdata;
      end

      if (grant_i || !if_req) begin
        starve_q <= 4'd0;
      end else if (grant_d && (starve_q < STARVE_LIM)) begin
        starve_q <= starve_q + 4'd1;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_if_q;
  logic [15:0] perf_d_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_if_q <= 16'd0;
      perf_d_q  <= 16'd0;
    end else begin
      if (stall_if && (perf_if_q != 16'hFFFF)) begin
        perf_if_q <= perf_if_q + 16'd1;
      end
      if (stall_mem && (perf_d_q != 16'hFFFF)) begin
        perf_d_q <= perf_d_q + 16'd1;
      end
    end
  end

  assign perf_if_wait = perf_if_q;
  assign perf_d_wait  = perf_d_q;
`else
  assign perf_if_wait = 16'd0;
  assign perf_d_wait  = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=4).
// A small memory model drives mem_rdata from mem_addr. Every access pushes
// its expected ack cycle, address, write flag and read data onto a per-port
// queue; a monitor pops and compares on each ack.

module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = 8'h00;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [7:0]  d_addr = 8'h00;
  logic [31:0] d_wdata = 32'h0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;
  logic [15:0] perf_if_wait;
  logic [15:0] perf_d_wait;

  mem_port_arbiter #(
    .ADDR_W(8), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(4)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .busy(busy),
    .perf_if_wait(perf_if_wait), .perf_d_wait(perf_d_wait)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pattern(input logic [7:0] a);
    if (a == 8'h10) return 32'hDEADBEEF;
    return {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  assign mem_rdata = mem_en ? pattern(mem_addr) : 32'h0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [7:0]  addr;
    logic        we;
    int          ack_cyc;
  } sb_t;

  sb_t q_i[$];
  sb_t q_d[$];
  logic sb_on = 1'b1;

  always @(negedge clk) begin
    sb_t e;
    #2;
    if (sb_on) begin
      if (if_ack) begin
        if (q_i.size() == 0) chk("if_ack_unexpected", 32'd1, 32'd0);
        else begin
          e = q_i.pop_front();
          chk("if_ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          chk("if_rdata", if_rdata, e.rdata);
          chk("if_mem_addr", {24'h0, mem_addr}, {24'h0, e.addr});
          chk("if_mem_we", {31'h0, mem_we}, 32'd0);
        end
      end
      if (d_ack) begin
        if (q_d.size() == 0) chk("d_ack_unexpected", 32'd1, 32'd0);
        else begin
          e = q_d.pop_front();
          chk("d_ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_mem_addr", {24'h0, mem_addr}, {24'h0, e.addr});
          chk("d_mem_we", {31'h0, mem_we}, {31'h0, e.we});
        end
      end
    end
  end

  // All tasks start and end just after a falling edge.
  task automatic fetch_access(input logic [7:0] a, input logic [31:0] exp_rd, input int lat);
    sb_t e;
    logic got;
    e.rdata = exp_rd; e.addr = a; e.we = 1'b0; e.ack_cyc = cyc + lat;
    q_i.push_back(e);
    if_req = 1'b1; if_addr = a;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (if_ack) begin got = 1'b1; break; end
    end
    chk("if_ack_seen", {31'h0, got}, 32'd1);
    if_req = 1'b0;
  endtask

  task automatic data_access(input logic we, input logic [7:0] a, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input int lat);
    sb_t e;
    logic got;
    e.rdata = exp_rd; e.addr = a; e.we = we; e.ack_cyc = cyc + lat;
    q_d.push_back(e);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    got = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (d_ack) begin got = 1'b1; break; end
    end
    chk("d_ack_seen", {31'h0, got}, 32'd1);
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("queues_drained", 32'(q_i.size() + q_d.size()), 32'd0);
    q_i.delete();
    q_d.delete();
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int nack;
    int last_i;

    vecs[0] = '{1'b0, 1'b0, 8'h10, 32'h0,         pattern(8'h10)};
    vecs[1] = '{1'b1, 1'b0, 8'h20, 32'h0,         pattern(8'h20)};
    vecs[2] = '{1'b1, 1'b1, 8'h30, 32'hCAFE_0001, pattern(8'h20)};
    vecs[3] = '{1'b0, 1'b0, 8'h00, 32'h0,         pattern(8'h00)};
    vecs[4] = '{1'b1, 1'b0, 8'hFF, 32'h0,         pattern(8'hFF)};
    vecs[5] = '{1'b0, 1'b0, 8'hFF, 32'h0,         pattern(8'hFF)};
    vecs[6] = '{1'b1, 1'b1, 8'h00, 32'hFFFF_FFFF, pattern(8'hFF)};
    vecs[7] = '{1'b1, 1'b0, 8'h01, 32'h0,         pattern(8'h01)};

    // Reset state
    do_reset();
    #1;
    chk("reset_ctrl", {26'h0, if_ack, d_ack, mem_en, mem_we, busy, stall_if}, 32'd0);
    chk("reset_if_rdata", if_rdata, 32'd0);
    chk("reset_d_rdata", d_rdata, 32'd0);
    chk("reset_mem_addr", {24'h0, mem_addr}, 32'd0);
    chk("reset_mem_wdata", mem_wdata, 32'd0);
    chk("reset_perf", {perf_if_wait, perf_d_wait}, 32'd0);
    @(negedge clk);

    // Fetch only: stall for two cycles, mem_en from the cycle after acceptance
    fork
      fetch_access(8'h10, 32'hDEADBEEF, MEM_LAT);
      begin
        #1;
        chk("t1_stall_c0", {31'h0, stall_if}, 32'd1);
        chk("t1_mem_en_c0", {31'h0, mem_en}, 32'd0);
        @(negedge clk); #1;
        chk("t1_stall_c1", {31'h0, stall_if}, 32'd1);
        chk("t1_mem_en_c1", {31'h0, mem_en}, 32'd1);
        chk("t1_mem_addr_c1", {24'h0, mem_addr}, 32'h10);
        @(negedge clk); #1;
        chk("t1_if_ack_c2", {31'h0, if_ack}, 32'd1);
      end
    join

    // Store: address/data stay stable even when the requester changes them
    begin
      sb_t e;
      e.rdata = 32'h0; e.addr = 8'h30; e.we = 1'b1; e.ack_cyc = cyc + MEM_LAT;
      q_d.push_back(e);
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h30; d_wdata = 32'h1234_5678;
      for (int k = 1; k <= 2; k++) begin
        @(negedge clk);
        chk("t3_mem_en", {31'h0, mem_en}, 32'd1);
        chk("t3_mem_we", {31'h0, mem_we}, 32'd1);
        chk("t3_mem_addr", {24'h0, mem_addr}, 32'h30);
        chk("t3_mem_wdata", mem_wdata, 32'h1234_5678);
        d_addr = 8'h31; d_wdata = 32'h0;
      end
      chk("t3_d_ack", {31'h0, d_ack}, 32'd1);
      d_req = 1'b0;
    end

    // Table-driven single accesses, issued back to back
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].is_d)
        data_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, MEM_LAT);
      else
        fetch_access(vecs[i].addr, vecs[i].exp_rdata, MEM_LAT);
    end
    repeat (2) @(negedge clk);
    chk("idle_after_table", {30'h0, busy, mem_en}, 32'd0);

    // Simultaneous requests: data first, fetch back to back
    do_reset();
    fork
      data_access(1'b0, 8'h20, 32'h0, pattern(8'h20), MEM_LAT);
      fetch_access(8'h24, pattern(8'h24), 2 * MEM_LAT);
    join
`ifdef ARB_PERF_CNT_EN
    chk("perf_if_wait", {16'h0, perf_if_wait}, 32'd4);
    chk("perf_d_wait", {16'h0, perf_d_wait}, 32'd2);
`else
    chk("perf_if_wait", {16'h0, perf_if_wait}, 32'd0);
    chk("perf_d_wait", {16'h0, perf_d_wait}, 32'd0);
`endif

    // Starvation: both requests held; four data acks then one fetch ack
    do_reset();
    sb_on = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h40;
    if_req = 1'b1; if_addr = 8'h50;
    nack = 0;
    last_i = -1;
    for (int c = 0; c < 200 && nack < 15; c++) begin
      @(negedge clk); #2;
      if (if_ack || d_ack) begin
        chk("starve_order", {31'h0, if_ack}, 32'(nack % 5 == 4));
        if (if_ack) begin
          if (last_i >= 0) chk("fetch_gap", 32'(cyc - last_i), 32'(5 * MEM_LAT));
          last_i = cyc;
        end
        nack++;
      end
    end
    chk("starve_ack_count", 32'(nack), 32'd15);
    @(negedge clk);
    d_req = 1'b0; if_req = 1'b0;
    repeat (6) @(negedge clk);
    do_reset();
    sb_on = 1'b1;

    // Reset in the completion cycle of a data grant: no ack, all idle after
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h20;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_no_d_ack", {31'h0, d_ack}, 32'd0);
    @(negedge clk);
    d_req = 1'b0;
    chk("t5_after_reset", {29'h0, mem_en, busy, d_ack}, 32'd0);
    chk("t5_d_rdata", d_rdata, 32'd0);
    reset = 1'b0;
    fetch_access(8'h60, pattern(8'h60), MEM_LAT);

    repeat (4) @(negedge clk);
    chk("final_queues", 32'(q_i.size() + q_d.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
